// File: rtl/memory_stage.sv
// M stage of the rv32i pipeline: E/M pipeline register plus a local word-organised data memory
// with RV32I byte/halfword/word load and store semantics.
module memory_stage #(
    parameter int unsigned DPW   = 32,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           stallM,
    input  logic           flushM,
    input  logic           regwriteE,
    input  logic           resultsrcE,
    input  logic           memwriteE,
    input  logic [2:0]     funct3E,
    input  logic [DPW-1:0] aluresultE,
    input  logic [DPW-1:0] WriteDataE,
    input  logic [4:0]     RdE,
    output logic           regwriteM,
    output logic           resultsrcM,
    output logic [DPW-1:0] aluresultM,
    output logic [DPW-1:0] ReadDataM,
    output logic [4:0]     RdM,
    output logic           misalignM
);

    logic           regwrite_q, resultsrc_q, memwrite_q;
    logic [2:0]     funct3_q;
    logic [DPW-1:0] aluresult_q, writedata_q;
    logic [4:0]     rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            memwrite_q  <= 1'b0;
            funct3_q    <= 3'b000;
            aluresult_q <= '0;
            writedata_q <= '0;
            rd_q        <= 5'd0;
        end else if (flushM) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            memwrite_q  <= 1'b0;
            funct3_q    <= 3'b000;
            aluresult_q <= '0;
            writedata_q <= '0;
            rd_q        <= 5'd0;
        end else if (!stallM) begin
            regwrite_q  <= regwriteE;
            resultsrc_q <= resultsrcE;
            memwrite_q  <= memwriteE;
            funct3_q    <= funct3E;
            aluresult_q <= aluresultE;
            writedata_q <= WriteDataE;
            rd_q        <= RdE;
        end
    end

    logic [DPW-1:0] mem [DEPTH];
    logic [AW-1:0]  widx;
    logic [1:0]     off;
    logic [DPW-1:0] rword;
    logic           is_half, is_word, misalign, valid;

    assign widx  = aluresult_q[AW+1:2];
    assign off   = aluresult_q[1:0];
    assign rword = mem[widx];

    assign is_half  = (funct3_q[1:0] == 2'b01);
    assign is_word  = (funct3_q[1:0] == 2'b10);
    assign misalign = (resultsrc_q | memwrite_q) &
                      ((is_half & off[0]) | (is_word & (off != 2'b00)));
    // Bubbles (all-zero register) must present zero load data.
    assign valid    = regwrite_q | resultsrc_q | memwrite_q;

    logic [7:0]     rbyte;
    logic [15:0]    rhalf;
    logic [DPW-1:0] rdata;

    assign rbyte = rword[{off, 3'b000} +: 8];
    assign rhalf = off[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        rdata = '0;
        unique case (funct3_q)
            3'b000:  rdata = {{24{rbyte[7]}}, rbyte};
            3'b001:  rdata = {{16{rhalf[15]}}, rhalf};
            3'b010:  rdata = rword;
            3'b100:  rdata = {24'd0, rbyte};
            3'b101:  rdata = {16'd0, rhalf};
            default: rdata = '0;
        endcase
    end

    logic [3:0]     be;
    logic [DPW-1:0] wdata;
    logic           mem_we;

    always_comb begin
        be    = 4'b0000;
        wdata = writedata_q;
        unique case (funct3_q)
            3'b000: begin
                be    = 4'b0001 << off;
                wdata = {4{writedata_q[7:0]}};
            end
            3'b001: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{writedata_q[15:0]}};
            end
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // A stalled store commits on the edge where stallM falls; misaligned stores are dropped.
    assign mem_we = memwrite_q & ~misalign & ~stallM;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign regwriteM  = regwrite_q;
    assign resultsrcM = resultsrc_q;
    assign aluresultM = aluresult_q;
    assign RdM        = rd_q;
    assign misalignM  = misalign;
    assign ReadDataM  = (valid && !misalign) ? rdata : '0;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: reset, load/store lanes, misalignment, stall/flush and the
// hand-off to a small writeback register model.
module tb_memory_stage;

    logic        clk, rst_n, stallM, flushM;
    logic        regwriteE, resultsrcE, memwriteE;
    logic [2:0]  funct3E;
    logic [31:0] aluresultE, WriteDataE;
    logic [4:0]  RdE;
    logic        regwriteM, resultsrcM, misalignM;
    logic [31:0] aluresultM, ReadDataM;
    logic [4:0]  RdM;

    int total = 0;
    int bad   = 0;

    memory_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stallM     (stallM),
        .flushM     (flushM),
        .regwriteE  (regwriteE),
        .resultsrcE (resultsrcE),
        .memwriteE  (memwriteE),
        .funct3E    (funct3E),
        .aluresultE (aluresultE),
        .WriteDataE (WriteDataE),
        .RdE        (RdE),
        .regwriteM  (regwriteM),
        .resultsrcM (resultsrcM),
        .aluresultM (aluresultM),
        .ReadDataM  (ReadDataM),
        .RdM        (RdM),
        .misalignM  (misalignM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal writeback register stage fed by the M outputs.
    logic [31:0] resultW;
    logic [4:0]  RdW;
    always_ff @(posedge clk) begin
        resultW <= resultsrcM ? ReadDataM : aluresultM;
        RdW     <= RdM;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_e(input logic rw, input logic rs, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
        regwriteE  = rw;
        resultsrcE = rs;
        memwriteE  = mw;
        funct3E    = f3;
        aluresultE = alu;
        WriteDataE = wd;
        RdE        = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".regwriteM"},  {31'd0, regwriteM},  32'd0);
        chk({tag, ".resultsrcM"}, {31'd0, resultsrcM}, 32'd0);
        chk({tag, ".aluresultM"}, aluresultM,          32'd0);
        chk({tag, ".ReadDataM"},  ReadDataM,           32'd0);
        chk({tag, ".RdM"},        {27'd0, RdM},        32'd0);
        chk({tag, ".misalignM"},  {31'd0, misalignM},  32'd0);
    endtask

    // Load/store opcodes as {regwrite, resultsrc, memwrite}.
    localparam logic [2:0] OpLoad  = 3'b110;
    localparam logic [2:0] OpStore = 3'b001;

    task automatic op(input logic [2:0] kind, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd);
        set_e(kind[2], kind[1], kind[0], f3, addr, wd, 5'd9);
        step();
    endtask

    initial begin
        rst_n  = 1'b1;
        stallM = 1'b0;
        flushM = 1'b0;
        set_e(1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 5'd3);

        // Asynchronous reset, observed before any clock edge, then held over 3 edges.
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("async_reset");
        repeat (3) @(posedge clk);
        #1 chk_zero_outputs("held_reset");

        // First edge after release loads the E inputs.
        set_e(1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
        rst_n = 1'b1;
        step();
        chk("sw_aligned.misalignM", {31'd0, misalignM}, 32'd0);
        chk("sw_loaded.aluresultM", aluresultM, 32'h0000_0010);

        op(OpLoad, 3'b010, 32'h10, 32'h0);
        chk("lw_0x10", ReadDataM, 32'hDEAD_BEEF);
        op(OpStore, 3'b000, 32'h11, 32'hABCD_EF80);
        op(OpLoad, 3'b000, 32'h11, 32'h0);
        chk("lb_0x11", ReadDataM, 32'hFFFF_FF80);
        op(OpLoad, 3'b100, 32'h11, 32'h0);
        chk("lbu_0x11", ReadDataM, 32'h0000_0080);
        op(OpLoad, 3'b010, 32'h10, 32'h0);
        chk("lw_after_sb", ReadDataM, 32'hDEAD_80EF);

        // Halfword lanes.
        op(OpStore, 3'b010, 32'h20, 32'h1122_3344);
        op(OpStore, 3'b001, 32'h22, 32'h1234_8001);
        op(OpLoad, 3'b001, 32'h22, 32'h0);
        chk("lh_0x22", ReadDataM, 32'hFFFF_8001);
        op(OpLoad, 3'b101, 32'h22, 32'h0);
        chk("lhu_0x22", ReadDataM, 32'h0000_8001);
        op(OpLoad, 3'b010, 32'h20, 32'h0);
        chk("lw_after_sh", ReadDataM, 32'h8001_3344);

        // Misaligned accesses and an undefined load size.
        op(OpStore, 3'b010, 32'h13, 32'hCAFE_F00D);
        chk("sw_0x13.misalignM", {31'd0, misalignM}, 32'd1);
        op(OpLoad, 3'b010, 32'h10, 32'h0);
        chk("lw_after_misaligned_sw", ReadDataM, 32'hDEAD_80EF);
        op(OpLoad, 3'b001, 32'h21, 32'h0);
        chk("lh_0x21.ReadDataM", ReadDataM, 32'd0);
        chk("lh_0x21.misalignM", {31'd0, misalignM}, 32'd1);
        op(OpLoad, 3'b011, 32'h10, 32'h0);
        chk("funct3_011.ReadDataM", ReadDataM, 32'd0);

        // Stalled store: outputs stable, memory unchanged until the release edge.
        op(OpStore, 3'b010, 32'h30, 32'h0102_0304);
        op(OpStore, 3'b010, 32'h30, 32'h55AA_55AA);
        set_e(1'b1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 5'd4);
        stallM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.aluresultM", aluresultM, 32'h30);
            chk("stall.RdM", {27'd0, RdM}, 32'd9);
            chk("stall.old_word", ReadDataM, 32'h0102_0304);
        end
        stallM = 1'b0;
        step();
        chk("stall_release.RdM", {27'd0, RdM}, 32'd4);
        chk("stall_release.lw_0x30", ReadDataM, 32'h55AA_55AA);

        // Flush beats stall; the pending E store becomes a bubble.
        set_e(1'b1, 1'b0, 1'b1, 3'b010, 32'h30, 32'h0BAD_F00D, 5'd6);
        stallM = 1'b1;
        flushM = 1'b1;
        step();
        chk("flush.regwriteM", {31'd0, regwriteM}, 32'd0);
        chk("flush.aluresultM", aluresultM, 32'd0);
        stallM = 1'b0;
        flushM = 1'b0;
        op(OpStore, 3'b000, 32'h30, 32'h0000_0000);
        op(OpLoad, 3'b010, 32'h30, 32'h0);
        chk("lw_0x30_after_flush", ReadDataM, 32'h55AA_5500);

        // Store dropped by reset coinciding with its commit edge.
        op(OpStore, 3'b010, 32'h30, 32'h7777_7777);
        rst_n = 1'b0;
        step();
        set_e(1'b1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 5'd2);
        rst_n = 1'b1;
        step();
        chk("lw_after_reset_store", ReadDataM, 32'h55AA_5500);

        // Pass-through into writeback.
        set_e(1'b1, 1'b0, 1'b0, 3'b010, 32'd5, 32'h0, 5'd7);
        step();
        chk("pt.regwriteM", {31'd0, regwriteM}, 32'd1);
        chk("pt.resultsrcM", {31'd0, resultsrcM}, 32'd0);
        chk("pt.aluresultM", aluresultM, 32'd5);
        chk("pt.RdM", {27'd0, RdM}, 32'd7);
        chk("pt.misalignM", {31'd0, misalignM}, 32'd0);
        set_e(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        step();
        chk("pt.resultW", resultW, 32'd5);
        chk("pt.RdW", {27'd0, RdW}, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
